// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one pipelined signed multiplier among NREQ requesters.
// Latency: operands registered 1 cycle after grant; product returns MULT_LAT+1 cycles after handshake.
// Backpressure: hold or reset withholds grants; responses cannot be stalled and pulse for exactly one cycle.
module booth_mult_arbiter #(
   parameter int DATAWIDTH = 8,
   parameter int NREQ      = 4,
   parameter int MULT_LAT  = 8,
   parameter int IDW       = 2
) (
   input  logic                      CLK,
   input  logic                      RSTn,
   input  logic                      hold,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*DATAWIDTH-1:0] req_a,
   input  logic [NREQ*DATAWIDTH-1:0] req_b,
   output logic [NREQ-1:0]           req_ready,
   output logic [DATAWIDTH-1:0]      mult_a,
   output logic [DATAWIDTH-1:0]      mult_b,
   input  logic [2*DATAWIDTH-1:0]    mult_result,
   output logic [NREQ-1:0]           rsp_valid,
   output logic [IDW-1:0]            rsp_id,
   output logic [2*DATAWIDTH-1:0]    rsp_data,
   output logic                      busy,
   output logic [3:0]                inflight
);

   // Tag travelling beside the multiplier. Stage 0 sits alongside mult_a/mult_b,
   // stages 1..MULT_LAT mirror the multiplier stages, so stage MULT_LAT lines up
   // with mult_result.
   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [IDW-1:0]       ptr_q, ptr_d;
   logic [DATAWIDTH-1:0] mult_a_q, mult_a_d;
   logic [DATAWIDTH-1:0] mult_b_q, mult_b_d;
   logic [3:0]           inflight_q, inflight_d;
   tag_t                 tag_q [MULT_LAT+1];
   tag_t                 tag_d [MULT_LAT+1];

   logic                 gnt_any;
   logic [IDW-1:0]       gnt_idx;
   logic [NREQ-1:0]      gnt_oh;
   logic [DATAWIDTH-1:0] sel_a, sel_b;

   // Round-robin pick: first pass scans ptr..NREQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      sel_a   = '0;
      sel_b   = '0;
      if (RSTn && !hold) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!gnt_any && req_valid[i] &&
                   ((pass == 0) ? (i >= int'(ptr_q)) : (i < int'(ptr_q)))) begin
                  gnt_any   = 1'b1;
                  gnt_idx   = IDW'(i);
                  gnt_oh[i] = 1'b1;
                  sel_a     = req_a[i*DATAWIDTH +: DATAWIDTH];
                  sel_b     = req_b[i*DATAWIDTH +: DATAWIDTH];
               end
            end
         end
      end
   end

   // Next-state: pointer advance, operand issue, tag shift and in-flight count.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end

      // Idle cycles drive zero operands so the multiplier sees a clean bubble.
      mult_a_d = sel_a;
      mult_b_d = sel_b;

      tag_d[0].vld = gnt_any;
      tag_d[0].id  = gnt_idx;
      for (int s = 1; s <= MULT_LAT; s++) begin
         tag_d[s] = tag_q[s-1];
      end

      // An operation counts from the edge after its handshake through its response cycle.
      case ({gnt_any, tag_q[MULT_LAT].vld})
         2'b10:   inflight_d = inflight_q + 4'd1;
         2'b01:   inflight_d = inflight_q - 4'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   // State registers; reset drops every in-flight tag so stale products are never reported.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         ptr_q      <= '0;
         mult_a_q   <= '0;
         mult_b_q   <= '0;
         inflight_q <= '0;
         for (int s = 0; s <= MULT_LAT; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         mult_a_q   <= mult_a_d;
         mult_b_q   <= mult_b_d;
         inflight_q <= inflight_d;
         for (int s = 0; s <= MULT_LAT; s++) begin
            tag_q[s] <= tag_d[s];
         end
      end
   end

   // One-hot response decode from the tag that is aligned with mult_result.
   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (tag_q[MULT_LAT].vld && (int'(tag_q[MULT_LAT].id) == i)) begin
            rsp_valid[i] = 1'b1;
         end
      end
   end

   assign req_ready = gnt_oh;
   assign mult_a    = mult_a_q;
   assign mult_b    = mult_b_q;
   assign rsp_id    = tag_q[MULT_LAT].id;
   assign rsp_data  = mult_result;
   assign inflight  = inflight_q;
   assign busy      = (inflight_q != 4'd0);

endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one pipelined signed Booth multiplier among NREQ requesters.
- Arbitrates issue slots round-robin and registers the winner's operands onto the multiplier inputs.
- Carries a valid/ID tag pipeline alongside the multiplier so each product returns to the requester that issued it.
- Sits between requesting datapath blocks and the multiplier's A/B/RESULT ports; the multiplier itself is instantiated outside this block.

Parameters:
- DATAWIDTH, 8, operand width; multiplier product width is 2*DATAWIDTH.
- NREQ, 4, number of requesters (2..8).
- MULT_LAT, 8, multiplier latency in cycles from A/B to RESULT; equals the multiplier stage count.
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- hold  in  1  when high, no new grants are given; in-flight operations still complete.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*DATAWIDTH  multiplicand per requester; requester i uses slice [i*DATAWIDTH +: DATAWIDTH].
- req_b  in  NREQ*DATAWIDTH  multiplier per requester; same slicing as req_a.
- req_ready  out  NREQ  one-hot grant, combinational.
- mult_a  out  DATAWIDTH  registered operand A to the multiplier.
- mult_b  out  DATAWIDTH  registered operand B to the multiplier.
- mult_result  in  2*DATAWIDTH  product from the multiplier RESULT port.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse marking a returned product.
- rsp_id  out  IDW  requester index of the current response.
- rsp_data  out  2*DATAWIDTH  product; equals mult_result.
- busy  out  1  high while any operation is in flight.
- inflight  out  4  count of issued operations not yet returned (0..MULT_LAT+1).

Behaviour:
- Reset: when RSTn is sampled low, the following clear to 0: mult_a, mult_b, every tag-pipe valid and ID, rsp_valid, busy, inflight; the round-robin pointer resets to 0.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is produced for any operation issued before reset, even though the multiplier pipeline still holds data.
- Arbitration:
  - Grants are considered only when hold=0 and RSTn=1.
  - Priority starts at index ptr and proceeds ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready[i]=1 only for the first i in that order with req_valid[i]=1; at most one grant per cycle.
  - Handshake = req_valid[i] & req_ready[i].
  - On a handshake with requester i, ptr <= (i+1) mod NREQ. With no handshake, ptr holds.
  - A requester must hold req_valid, req_a and req_b stable until it sees its handshake.
- Issue stage, cycle t handshake:
  - At edge t+1, mult_a/mult_b load the winner's operands and tag stage 0 loads {1, i}.
  - With no handshake, mult_a/mult_b load 0 and stage 0 loads valid=0.
- Tag pipeline: MULT_LAT stages that always advance; the multiplier cannot stall.
- Response timing: the final tag stage is valid in cycle t+1+MULT_LAT, aligned with mult_result. Total request-to-response latency is MULT_LAT+1 cycles (9 at default).
- Response outputs:
  - rsp_valid = one-hot decode of the final stage when that stage is valid, else 0.
  - rsp_id = final-stage ID.
  - rsp_data = mult_result.
  - There is no response backpressure; responders must accept every pulse.
- Throughput: one issue per cycle; back-to-back operations from the same or different requesters are allowed.
- Arithmetic: operands are signed two's complement; rsp_data is the full 2*DATAWIDTH signed product. This block does no arithmetic beyond passing data through.
- inflight counter:
  - +1 on handshake, −1 on final-stage valid; both in the same cycle leaves it unchanged.
  - It never exceeds MULT_LAT+1.
  - busy = (inflight != 0).
- hold timing: hold asserted in cycle t blocks the grant in cycle t. Operations already issued still return at their normal times.

Test Plan:
- Reset then single request: req 0 with a=3, b=5 → mult_a=3, mult_b=5 one cycle later; 9 cycles after the handshake, rsp_valid=0001, rsp_id=0, rsp_data=16'h000F; inflight goes 1→0 and busy drops the same cycle.
- Signed operands: req 2 with a=8'hFD (−3), b=7 → rsp_id=2, rsp_data=16'hFFEB (−21); a=8'h80, b=8'h80 → 16'h4000.
- All four requesters valid continuously from ptr=0 → grant order 0,1,2,3,0,…; responses follow in the same order, one per cycle with no gaps; inflight saturates at 9.
- Round-robin fairness: req 1 and req 3 always valid → grants alternate 1,3,1,3; req 0 asserted later wins when ptr wraps past 3.
- hold: hold=1 for 5 cycles with requests pending → req_ready=0 throughout; the 3 previously issued operations still return on schedule; grants resume the cycle after hold falls.
- Reset mid-flight: RSTn low for 1 cycle with 4 operations in flight → no rsp_valid afterwards for those operations; inflight=0 and ptr=0; a new request 3×5 returns 16'h000F 9 cycles after its handshake.
